// File: rtl/dds_quarter_lut.sv
// Quarter-wave sine/cosine lookup stage: folds the phase into one quadrant,
// reads a registered quarter-table PROM and restores the sign of the result.
module dds_quarter_lut #(
  parameter int PHASE_W = 13,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 24,
  parameter int OUT_W   = 32,
  parameter int ROM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic                     Fg_CLK,
  input  logic                     RESETn,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [PHASE_W-1:0]       in_phase,
  input  logic                     in_sel,
  output logic [ADDR_W-1:0]        rom_addr,
  output logic                     rom_ce,
  input  logic [DATA_W-1:0]        rom_data,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_sel,
  output logic [CNT_W-1:0]         out_count
);

  localparam logic [PHASE_W-1:0] QTR = PHASE_W'(1) << (PHASE_W - 2);

  // Returns {sign, address}; odd quadrants walk the table backwards.
  function automatic logic [ADDR_W:0] fold_phase(input logic [PHASE_W-1:0] phase,
                                                 input logic sel);
    logic [PHASE_W-1:0] p;
    logic [ADDR_W-1:0]  idx;
    p   = sel ? phase + QTR : phase;
    idx = p[ADDR_W-1:0];
    return {p[PHASE_W-1], p[PHASE_W-2] ? ~idx : idx};
  endfunction

  function automatic logic signed [OUT_W-1:0] signed_align(input logic [DATA_W-1:0] m,
                                                           input logic neg);
    logic signed [OUT_W-1:0] mag;
    mag = signed'(OUT_W'(m) << (OUT_W - 1 - DATA_W));
    return neg ? -mag : mag;
  endfunction

  logic [ADDR_W:0]         fold_d;
  logic signed [OUT_W-1:0] data_d;

  logic [ADDR_W-1:0]       addr_q;
  logic [ROM_LAT:0]        vld_q;
  logic [ROM_LAT:0]        sgn_q;
  logic [ROM_LAT:0]        sel_q;
  logic                    out_valid_q;
  logic signed [OUT_W-1:0] out_data_q;
  logic                    out_sel_q;
  logic [CNT_W-1:0]        cnt_q;

  assign fold_d = fold_phase(in_phase, in_sel);
  assign data_d = signed_align(rom_data, sgn_q[ROM_LAT]);

  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      addr_q      <= '0;
      vld_q       <= '0;
      sgn_q       <= '0;
      sel_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 1'b0;
      cnt_q       <= '0;
    end else if (clr) begin
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // Stage 0: fold and register the PROM address
      if (in_valid) begin
        addr_q <= fold_d[ADDR_W-1:0];
      end
      // Delay line: index k holds the sample k clocks past stage 0
      vld_q <= {vld_q[ROM_LAT-1:0], in_valid};
      sgn_q <= {sgn_q[ROM_LAT-1:0], in_valid ? fold_d[ADDR_W] : sgn_q[0]};
      sel_q <= {sel_q[ROM_LAT-1:0], in_valid ? in_sel : sel_q[0]};
      // Output stage: sign restore, aligned with returning PROM data
      out_valid_q <= vld_q[ROM_LAT];
      if (vld_q[ROM_LAT]) begin
        out_data_q <= data_d;
        out_sel_q  <= sel_q[ROM_LAT];
        cnt_q      <= cnt_q + 1'b1;
      end
    end
  end

  assign rom_addr  = addr_q;
  assign rom_ce    = vld_q[0];
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_dds_quarter_lut.sv
// Bench for dds_quarter_lut: addr+1 PROM model, quadrant-arithmetic reference
// and an ordered queue of expected outputs keyed by their due clock edge.
module tb_dds_quarter_lut;

  localparam int PHASE_W = 13;
  localparam int ADDR_W  = 11;
  localparam int DATA_W  = 24;
  localparam int OUT_W   = 32;
  localparam int ROM_LAT = 2;
  localparam int CNT_W   = 16;
  localparam int FULL    = 1 << PHASE_W;
  localparam int QUARTER = FULL / 4;
  localparam int SHIFT   = OUT_W - 1 - DATA_W;

  logic                    Fg_CLK = 1'b0;
  logic                    RESETn = 1'b0;
  logic                    clr = 1'b0;
  logic                    in_valid = 1'b0;
  logic [PHASE_W-1:0]      in_phase = '0;
  logic                    in_sel = 1'b0;
  logic [ADDR_W-1:0]       rom_addr, rom_addr2;
  logic                    rom_ce, rom_ce2;
  logic [DATA_W-1:0]       rom_data = '0;
  logic                    out_valid, out_valid2;
  logic signed [OUT_W-1:0] out_data, out_data2;
  logic                    out_sel, out_sel2;
  logic [CNT_W-1:0]        out_count;
  logic [3:0]              out_count2;

  dds_quarter_lut #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_W(OUT_W),
                    .ROM_LAT(ROM_LAT), .CNT_W(CNT_W)) dut (
    .Fg_CLK(Fg_CLK), .RESETn(RESETn), .clr(clr), .in_valid(in_valid),
    .in_phase(in_phase), .in_sel(in_sel), .rom_addr(rom_addr), .rom_ce(rom_ce),
    .rom_data(rom_data), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_count(out_count));

  // Narrow-counter instance for the wrap check; same addresses, so it shares the PROM.
  dds_quarter_lut #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_W(OUT_W),
                    .ROM_LAT(ROM_LAT), .CNT_W(4)) dut_w4 (
    .Fg_CLK(Fg_CLK), .RESETn(RESETn), .clr(clr), .in_valid(in_valid),
    .in_phase(in_phase), .in_sel(in_sel), .rom_addr(rom_addr2), .rom_ce(rom_ce2),
    .rom_data(rom_data), .out_valid(out_valid2), .out_data(out_data2),
    .out_sel(out_sel2), .out_count(out_count2));

  always #5 Fg_CLK = ~Fg_CLK;

  // Registered PROM, two clocks from address to data, content = addr+1
  logic [ADDR_W-1:0] rom_a1 = '0;
  always @(posedge Fg_CLK) begin
    if (rom_ce) rom_a1 <= rom_addr;
    rom_data <= DATA_W'(rom_a1) + DATA_W'(1);
  end

  typedef struct { int due; int data; bit sel; } exp_t;
  exp_t q[$];

  int tests = 0;
  int fails = 0;
  int edge_n = 0;
  int cnt = 0;
  int exp_addr = 0;
  int exp_data = 0;
  bit exp_sel = 0;
  bit exp_ce = 0;
  bit exp_v = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic void ref_fold(input int phase, input bit sel, output int addr, output bit neg);
    int p, quad, off;
    p    = sel ? (phase + QUARTER) % FULL : phase % FULL;
    quad = p / QUARTER;
    off  = p % QUARTER;
    addr = (quad == 1 || quad == 3) ? QUARTER - 1 - off : off;
    neg  = (quad >= 2);
  endfunction

  task automatic step(input bit v, input int phase, input bit sel, input bit c);
    int a;
    bit n;
    exp_t e;
    in_valid = v;
    in_phase = PHASE_W'(phase);
    in_sel   = sel;
    clr      = c;
    if (c) begin
      q.delete();
      cnt    = 0;
      exp_ce = 0;
    end else if (v) begin
      ref_fold(phase, sel, a, n);
      exp_addr = a;
      exp_ce   = 1;
      e.due  = edge_n + 1 + ROM_LAT + 1;
      e.data = n ? -((a + 1) * (1 << SHIFT)) : (a + 1) * (1 << SHIFT);
      e.sel  = sel;
      q.push_back(e);
    end else begin
      exp_ce = 0;
    end
    @(posedge Fg_CLK);
    edge_n++;
    #1;
    exp_v = (q.size() > 0) && (q[0].due == edge_n);
    if (exp_v) begin
      e = q.pop_front();
      exp_data = e.data;
      exp_sel  = e.sel;
      cnt++;
    end
    chk("rom_ce", 32'(rom_ce), 32'(exp_ce));
    chk("rom_addr", 32'(rom_addr), exp_addr);
    chk("out_valid", 32'(out_valid), 32'(exp_v));
    chk("out_data", out_data, exp_data);
    chk("out_sel", 32'(out_sel), 32'(exp_sel));
    chk("out_count", 32'(out_count), cnt & 32'hFFFF);
    chk("out_valid_w4", 32'(out_valid2), 32'(exp_v));
    chk("out_count_w4", 32'(out_count2), cnt & 32'hF);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic rst_check(input string tag);
    chk({tag, "_addr"}, 32'(rom_addr), 0);
    chk({tag, "_ce"}, 32'(rom_ce), 0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_sel"}, 32'(out_sel), 0);
    chk({tag, "_count"}, 32'(out_count), 0);
    chk({tag, "_count_w4"}, 32'(out_count2), 0);
  endtask

  initial begin
    // Power-on reset
    #12;
    rst_check("reset");
    @(negedge Fg_CLK);
    RESETn = 1'b1;
    idle(2);

    // Directed sine phases, each followed by a drain
    step(1, 'h0000, 0, 0); chk("addr_sin_0000", 32'(rom_addr), 'h000); idle(3);
    chk("data_sin_0000", out_data, 32'h1 << 7);
    step(1, 'h0800, 0, 0); chk("addr_sin_0800", 32'(rom_addr), 'h7FF); idle(3);
    chk("data_sin_0800", out_data, 32'h800 << 7);
    step(1, 'h1000, 0, 0); chk("addr_sin_1000", 32'(rom_addr), 'h000); idle(3);
    chk("data_sin_1000", out_data, -(32'h1 << 7));
    step(1, 'h1FFF, 0, 0); chk("addr_sin_1FFF", 32'(rom_addr), 'h000); idle(3);
    chk("data_sin_1FFF", out_data, -(32'h1 << 7));

    // Directed cosine phases
    step(1, 'h0000, 1, 0); chk("addr_cos_0000", 32'(rom_addr), 'h7FF); idle(3);
    chk("data_cos_0000", out_data, 32'h800 << 7);
    chk("sel_cos_0000", 32'(out_sel), 1);
    step(1, 'h1000, 1, 0); chk("addr_cos_1000", 32'(rom_addr), 'h7FF); idle(3);
    chk("data_cos_1000", out_data, -(32'h800 << 7));

    // Back-to-back alternating sin/cos stream
    step(0, 0, 0, 1);
    for (int i = 0; i < 4096; i++) step(1, int'($urandom_range(FULL - 1)), i[0], 0);
    idle(4);
    chk("stream_count", 32'(out_count), 4096);

    // clr one cycle into a 3-sample burst
    step(1, 'h0123, 0, 0);
    step(1, 'h0456, 1, 1);
    step(1, 'h0789, 0, 0);
    idle(4);
    chk("clr_count", 32'(out_count), 1);

    // Asynchronous reset between edges, mid-burst
    step(1, 'h0321, 0, 0);
    step(1, 'h1654, 1, 0);
    step(1, 'h0A0A, 0, 0);
    in_valid = 1'b0;
    #2;
    RESETn = 1'b0;
    #1;
    rst_check("midrst");
    q.delete();
    cnt = 0; exp_addr = 0; exp_data = 0; exp_sel = 0; exp_ce = 0;
    @(negedge Fg_CLK);
    RESETn = 1'b1;
    idle(5);

    // Narrow counter wrap: 17 outputs leave it at 1
    step(0, 0, 0, 1);
    for (int i = 0; i < 17; i++) step(1, int'($urandom_range(FULL - 1)), 0, 0);
    idle(4);
    chk("wrap_count_w4", 32'(out_count2), 1);

    // Randomised traffic with occasional clr
    for (int i = 0; i < 800; i++)
      step(($urandom_range(3) != 0), int'($urandom_range(FULL - 1)), $urandom_range(1) == 1,
           ($urandom_range(39) == 0));
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dds_quarter_lut.md
Name: dds_quarter_lut

Overview:
Parametrised quarter-wave sine/cosine lookup stage for the DDS datapath. It takes a phase word per sample and a sin/cos select. It folds the phase into one quadrant and drives an external registered coefficient PROM holding only 2^ADDR_W quarter-wave magnitudes. It restores the sign and emits a signed, MSB-aligned amplitude with a valid strobe. It sits between the phase accumulator and the DAC formatter and replaces the fixed full-table lookup of the previous generation.

Parameters:
PHASE_W, 13, phase word width; must equal ADDR_W+2
ADDR_W, 11, quarter-table address width
DATA_W, 24, unsigned magnitude width returned by the PROM
OUT_W, 32, signed output width; must be at least DATA_W+1
ROM_LAT, 2, PROM read latency in clocks from rom_addr to rom_data (2 = registered output, oce tied high)
CNT_W, 16, output sample counter width

Ports:
Fg_CLK  in  1  system clock; all logic on rising edge
RESETn  in  1  asynchronous active-low reset
clr  in  1  synchronous flush of pipeline valids and counter
in_valid  in  1  phase sample present this cycle
in_phase  in  PHASE_W  unsigned phase, full circle = 2^PHASE_W
in_sel  in  1  0 = sine, 1 = cosine
rom_addr  out  ADDR_W  PROM address
rom_ce  out  1  PROM enable; high when the registered stage-0 valid is high
rom_data  in  DATA_W  PROM magnitude, ROM_LAT cycles after rom_addr
out_valid  out  1  out_data valid
out_data  out  OUT_W  signed two's-complement amplitude
out_sel  out  1  in_sel of the sample that produced out_data
out_count  out  CNT_W  number of out_valid pulses since reset/clr, wraps

Behaviour:
- Reset (async, RESETn=0): rom_addr=0, rom_ce=0, out_valid=0, out_data=0, out_sel=0, out_count=0, all internal valid/sign/sel pipeline bits cleared. Outputs return to normal on the first edge after release.
- PROM content contract: entry k = round((2^DATA_W-1)*sin(2*pi*(k+0.5)/2^PHASE_W)). The half-LSB offset makes the quadrant mirror exact.
- Phase fold, stage 0 (registered on in_valid):
  - Effective phase p = in_phase for sine, or in_phase + 2^(PHASE_W-2) mod 2^PHASE_W for cosine.
  - q = p[PHASE_W-1:PHASE_W-2], idx = p[ADDR_W-1:0].
  - q0: addr=idx, sign+. q1: addr=~idx, sign+. q2: addr=idx, sign-. q3: addr=~idx, sign-.
  - rom_addr is registered. rom_ce = stage-0 valid.
  - When in_valid=0, rom_addr holds its previous value.
- Delay line: valid, sign and sel are carried ROM_LAT stages alongside the PROM access. No backpressure; a new sample is accepted every cycle.
- Output stage (registered): mag = {1'b0, rom_data, (OUT_W-1-DATA_W) zeros}; out_data = sign ? -mag : mag.
  - No overflow is possible: max |mag| < 2^(OUT_W-1).
  - out_data and out_sel update only when the delayed valid is high; otherwise they hold. out_valid follows the delayed valid.
- Latency: a sample accepted at edge E appears at edge E+ROM_LAT+1 (3 clocks at default). Throughput is 1/clock.
- out_count increments on every cycle with out_valid=1 and wraps 2^CNT_W-1 -> 0.
- clr=1 at an edge:
  - Clears all pipeline valids, out_valid and out_count.
  - An in_valid in the same cycle is dropped.
  - out_data/out_sel hold their values.
  - rom_addr is not updated that cycle.
- Reset mid-stream: in-flight samples are discarded; no out_valid for them after release.

Test Plan:
- PROM model returns addr+1, ROM_LAT=2, defaults. Sine phases 0x0000, 0x0800, 0x1000, 0x1FFF -> rom_addr 0x000, 0x7FF, 0x000, 0x000; out_data = +1<<7, +0x800<<7, -(1<<7), -(1<<7); each 3 clocks after input.
- Cosine phase 0x0000 -> rom_addr 0x7FF, out_data=+0x800<<7, out_sel=1. Cosine phase 0x1000 -> rom_addr 0x7FF, out_data=-(0x800<<7).
- Back-to-back stream of 4096 alternating sin/cos samples -> out_valid continuous for 4096 cycles starting 3 clocks after first input; out_count=4096; out_sel alternates.
- Drive clr one cycle into a 3-sample burst -> no out_valid for samples in flight or on the clr cycle; out_count=0; the next sample appears 3 clocks later.
- Assert RESETn=0 asynchronously mid-burst (between edges) -> all outputs go to 0 immediately; no stale out_valid after release.
- out_count preset near wrap (CNT_W=4, 17 samples) -> out_count reads 1 after the 17th output.
